regbank_scoreboard: RTL and testbench

//  Parametrised multi-port architectural register bank with a tagged valid scoreboard.

---
 rtl/regbank_pkg.sv | 21 ++
 rtl/regbank_wb_select.sv | 41 ++++
 rtl/regbank_scoreboard.sv | 105 ++++++++++
 tb/tb_regbank_scoreboard.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared widths, types and the writeback request bundle
// for the tagged register bank scoreboard.
package regbank_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int TAGW  = 6;
  localparam int NRD   = 6;
  localparam int NWR   = 2;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [TAGW-1:0] tag_t;
  typedef logic [XLEN-1:0] xdata_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    tag_t      tag;
    xdata_t    data;
  } wb_req_t;
endpackage

// File: rtl/regbank_wb_select.sv
// Per-register writeback arbiter: tag match, alloc
// collision drop and highest-port-wins selection.
module regbank_wb_select
  import regbank_pkg::*;
#(
  parameter int NP      = NWR,
  parameter int REG_IDX = 1
) (
  input  wb_req_t [NP-1:0] i_wb,
  input  logic             i_valid,
  input  tag_t             i_tag,
  input  logic             i_alloc_hit,
  output logic             o_accept,
  output xdata_t           o_data
);
  logic [NP-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NP; i++) begin
      w_hit[i] = i_wb[i].en
        && (i_wb[i].addr == reg_addr_t'(REG_IDX))
        && (REG_IDX != 0)
        && !i_valid
        && (i_wb[i].tag == i_tag)
        && !i_alloc_hit;
    end
  end

  // Later ports overwrite earlier ones.
  always_comb begin
    o_accept = 1'b0;
    o_data   = '0;
    for (int i = 0; i < NP; i++) begin
      if (w_hit[i]) begin
        o_accept = 1'b1;
        o_data   = i_wb[i].data;
      end
    end
  end
endmodule

// File: rtl/regbank_scoreboard.sv
// Multi-port register bank with tagged valid scoreboard,
// writeback bypass and flush recovery.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int RD_PORTS = NRD,
  parameter int WR_PORTS = NWR
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [RD_PORTS*AW-1:0]     i_rd_addr,
  output logic [RD_PORTS*XLEN-1:0]   o_rd_data,
  output logic [RD_PORTS-1:0]        o_rd_valid,
  output logic [RD_PORTS*TAGW-1:0]   o_rd_tag,
  input  logic                       i_alloc_en,
  input  logic [AW-1:0]              i_alloc_addr,
  input  logic [TAGW-1:0]            i_alloc_tag,
  input  logic [WR_PORTS-1:0]        i_wb_en,
  input  logic [WR_PORTS*AW-1:0]     i_wb_addr,
  input  logic [WR_PORTS*TAGW-1:0]   i_wb_tag,
  input  logic [WR_PORTS*XLEN-1:0]   i_wb_data,
  input  logic                       i_flush,
  output logic [NREGS-1:0]           o_register_valid
);
  xdata_t                r_data [NREGS];
  tag_t                  r_tag  [NREGS];
  logic [NREGS-1:0]      r_valid;

  wb_req_t [WR_PORTS-1:0] w_wb;
  logic [NREGS-1:0]       w_alloc_hit;
  logic [NREGS-1:0]       w_acc;
  xdata_t                 w_wdata [NREGS];

  always_comb begin
    w_wb = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      w_wb[i].en   = i_wb_en[i];
      w_wb[i].addr = i_wb_addr[i*AW +: AW];
      w_wb[i].tag  = i_wb_tag[i*TAGW +: TAGW];
      w_wb[i].data = i_wb_data[i*XLEN +: XLEN];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    assign w_alloc_hit[g] = i_alloc_en
      && (i_alloc_addr == reg_addr_t'(g))
      && (g != 0);

    regbank_wb_select #(
      .NP      (WR_PORTS),
      .REG_IDX (g)
    ) u_sel (
      .i_wb        (w_wb),
      .i_valid     (r_valid[g]),
      .i_tag       (r_tag[g]),
      .i_alloc_hit (w_alloc_hit[g]),
      .o_accept    (w_acc[g]),
      .o_data      (w_wdata[g])
    );
  end

  // x0 is only ever touched by reset and flush, so it stays 0/valid/tag 0.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_data[r] <= '0;
        r_tag[r]  <= '0;
      end
      r_valid <= '1;
    end else if (i_flush) begin
      for (int r = 0; r < NREGS; r++) begin
        r_tag[r] <= '0;
      end
      r_valid <= '1;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_alloc_hit[r]) begin
          r_valid[r] <= 1'b0;
          r_tag[r]   <= i_alloc_tag;
        end else if (w_acc[r]) begin
          r_valid[r] <= 1'b1;
          r_data[r]  <= w_wdata[r];
        end
      end
    end
  end

  always_comb begin
    o_rd_data  = '0;
    o_rd_valid = '0;
    o_rd_tag   = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (w_acc[i_rd_addr[p*AW +: AW]]) begin
        o_rd_data[p*XLEN +: XLEN] = w_wdata[i_rd_addr[p*AW +: AW]];
        o_rd_valid[p]             = 1'b1;
      end else begin
        o_rd_data[p*XLEN +: XLEN] = r_data[i_rd_addr[p*AW +: AW]];
        o_rd_valid[p]             = r_valid[i_rd_addr[p*AW +: AW]];
      end
      o_rd_tag[p*TAGW +: TAGW] = r_tag[i_rd_addr[p*AW +: AW]];
    end
  end

  assign o_register_valid = r_valid;
endmodule

// File: tb/tb_regbank_scoreboard.sv
// Directed table-driven bench for regbank_scoreboard.
module tb_regbank_scoreboard;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AWD = 5;
  localparam int TW = 6;
  localparam int RP = 6;
  localparam int WP = 2;

  logic              clk;
  logic              rst_n;
  logic [RP*AWD-1:0] rd_addr;
  logic [RP*XL-1:0]  rd_data;
  logic [RP-1:0]     rd_valid;
  logic [RP*TW-1:0]  rd_tag;
  logic              alloc_en;
  logic [AWD-1:0]    alloc_addr;
  logic [TW-1:0]     alloc_tag;
  logic [WP-1:0]     wb_en;
  logic [WP*AWD-1:0] wb_addr;
  logic [WP*TW-1:0]  wb_tag;
  logic [WP*XL-1:0]  wb_data;
  logic              flush;
  logic [NR-1:0]     reg_valid;

  int checks = 0;
  int failures = 0;

  regbank_scoreboard dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_rd_addr        (rd_addr),
    .o_rd_data        (rd_data),
    .o_rd_valid       (rd_valid),
    .o_rd_tag         (rd_tag),
    .i_alloc_en       (alloc_en),
    .i_alloc_addr     (alloc_addr),
    .i_alloc_tag      (alloc_tag),
    .i_wb_en          (wb_en),
    .i_wb_addr        (wb_addr),
    .i_wb_tag         (wb_tag),
    .i_wb_data        (wb_data),
    .i_flush          (flush),
    .o_register_valid (reg_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ae;
    logic [4:0]  aa;
    logic [5:0]  at;
    logic        we0;
    logic [4:0]  wa0;
    logic [5:0]  wt0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [5:0]  wt1;
    logic [31:0] wd1;
    logic        fl;
    int          rp;
    logic [4:0]  ra;
    logic [31:0] ed;
    logic        ev;
    logic        ct;
    logic [5:0]  et;
    logic [31:0] erv;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(
    input logic ae, input logic [4:0] aa, input logic [5:0] at,
    input logic we0, input logic [4:0] wa0, input logic [5:0] wt0,
    input logic [31:0] wd0,
    input logic we1, input logic [4:0] wa1, input logic [5:0] wt1,
    input logic [31:0] wd1,
    input logic fl, input int rp, input logic [4:0] ra,
    input logic [31:0] ed, input logic ev, input logic ct,
    input logic [5:0] et, input logic [31:0] erv);
    vec_t v;
    v.ae = ae; v.aa = aa; v.at = at;
    v.we0 = we0; v.wa0 = wa0; v.wt0 = wt0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wt1 = wt1; v.wd1 = wd1;
    v.fl = fl; v.rp = rp; v.ra = ra;
    v.ed = ed; v.ev = ev; v.ct = ct; v.et = et; v.erv = erv;
    vq.push_back(v);
  endtask

  task automatic idle();
    alloc_en = 0; alloc_addr = '0; alloc_tag = '0;
    wb_en = '0; wb_addr = '0; wb_tag = '0; wb_data = '0;
    flush = 0; rd_addr = '0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    // test 1: reset
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int p = 0; p < RP; p++) rd_addr[p*AWD +: AWD] = 5'(p + 1);
    #1;
    chk("reset_regvalid", reg_valid, 32'hFFFF_FFFF);
    for (int p = 0; p < RP; p++) begin
      chk($sformatf("reset_rd_data%0d", p), rd_data[p*XL +: XL], 32'h0);
      chk($sformatf("reset_rd_valid%0d", p), 32'(rd_valid[p]), 32'h1);
    end

    // ae aa at | we0 wa0 wt0 wd0 | we1 wa1 wt1 wd1 | fl rp ra | ed ev ct et | erv
    add(1,5,3, 0,0,0,0, 0,0,0,0, 0,0,5, 32'h0,1,0,0, 32'hFFFF_FFDF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,1,5, 32'h0,0,1,3, 32'hFFFF_FFDF);
    add(0,0,0, 1,5,3,32'hFF, 0,0,0,0, 0,2,5, 32'hFF,1,0,0, 32'hFFFF_FFFF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,3,5, 32'hFF,1,0,0, 32'hFFFF_FFFF);
    add(1,2,1, 0,0,0,0, 0,0,0,0, 0,4,2, 32'h0,1,0,0, 32'hFFFF_FFFB);
    add(1,2,4, 0,0,0,0, 0,0,0,0, 0,5,2, 32'h0,0,1,1, 32'hFFFF_FFFB);
    add(0,0,0, 1,2,1,32'hAA, 0,0,0,0, 0,0,2, 32'h0,0,1,4, 32'hFFFF_FFFB);
    add(0,0,0, 0,0,0,0, 1,2,4,32'hBB, 0,1,2, 32'hBB,1,0,0, 32'hFFFF_FFFF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,2,2, 32'hBB,1,0,0, 32'hFFFF_FFFF);
    add(1,0,7, 1,0,0,32'h55, 0,0,0,0, 0,3,0, 32'h0,1,1,0, 32'hFFFF_FFFF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,4,0, 32'h0,1,1,0, 32'hFFFF_FFFF);
    add(1,9,1, 0,0,0,0, 0,0,0,0, 0,5,9, 32'h0,1,0,0, 32'hFFFF_FDFF);
    add(0,0,0, 0,0,0,0, 1,9,1,32'h99, 0,5,9, 32'h99,1,0,0, 32'hFFFF_FFFF);
    add(1,9,5, 0,0,0,0, 0,0,0,0, 0,0,9, 32'h99,1,0,0, 32'hFFFF_FDFF);
    add(1,9,2, 0,0,0,0, 1,9,5,32'h77, 0,1,9, 32'h99,0,1,5, 32'hFFFF_FDFF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,2,9, 32'h99,0,1,2, 32'hFFFF_FDFF);
    add(0,0,0, 1,9,2,32'h11, 1,9,2,32'h22, 0,0,9, 32'h22,1,0,0, 32'hFFFF_FFFF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,1,9, 32'h22,1,0,0, 32'hFFFF_FFFF);
    add(1,3,1, 0,0,0,0, 0,0,0,0, 0,2,3, 32'h0,1,0,0, 32'hFFFF_FFF7);
    add(1,4,2, 0,0,0,0, 0,0,0,0, 0,3,3, 32'h0,0,1,1, 32'hFFFF_FFE7);
    add(1,6,3, 0,0,0,0, 0,0,0,0, 0,4,4, 32'h0,0,1,2, 32'hFFFF_FFA7);
    add(0,0,0, 1,3,1,32'hDEAD, 0,0,0,0, 1,5,6, 32'h0,0,1,3, 32'hFFFF_FFFF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,3, 32'h0,1,1,0, 32'hFFFF_FFFF);
    add(0,0,0, 1,3,0,32'h1234, 0,0,0,0, 0,1,3, 32'h0,1,1,0, 32'hFFFF_FFFF);
    add(0,0,0, 0,0,0,0, 0,0,0,0, 0,2,6, 32'h0,1,1,0, 32'hFFFF_FFFF);

    foreach (vq[k]) begin
      vec_t v;
      v = vq[k];
      @(negedge clk);
      idle();
      alloc_en = v.ae; alloc_addr = v.aa; alloc_tag = v.at;
      wb_en = {v.we1, v.we0};
      wb_addr = {v.wa1, v.wa0};
      wb_tag = {v.wt1, v.wt0};
      wb_data = {v.wd1, v.wd0};
      flush = v.fl;
      rd_addr[v.rp*AWD +: AWD] = v.ra;
      #1;
      chk($sformatf("v%0d_rd_data", k), rd_data[v.rp*XL +: XL], v.ed);
      chk($sformatf("v%0d_rd_valid", k), 32'(rd_valid[v.rp]), 32'(v.ev));
      if (v.ct)
        chk($sformatf("v%0d_rd_tag", k), 32'(rd_tag[v.rp*TW +: TW]),
            32'(v.et));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_regvalid", k), reg_valid, v.erv);
    end

    // reset during a pending alloc
    @(negedge clk);
    idle();
    alloc_en = 1; alloc_addr = 5'd7; alloc_tag = 6'd1;
    wb_en = 2'b01; wb_addr = {5'd0, 5'd9}; wb_tag = '0; wb_data = '0;
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_alloc_regvalid", reg_valid, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    rst_n = 1;
    rd_addr[0 +: AWD] = 5'd5;
    rd_addr[AWD +: AWD] = 5'd2;
    rd_addr[2*AWD +: AWD] = 5'd9;
    rd_addr[3*AWD +: AWD] = 5'd7;
    #1;
    chk("rst_r5_data", rd_data[0 +: XL], 32'h0);
    chk("rst_r2_data", rd_data[XL +: XL], 32'h0);
    chk("rst_r9_data", rd_data[2*XL +: XL], 32'h0);
    chk("rst_r7_valid", 32'(rd_valid[3]), 32'h1);
    chk("rst_r7_tag", 32'(rd_tag[3*TW +: TW]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
